// File: rtl/sd_cmd_tx_ctrl.sv
// sd_cmd_tx_ctrl
// Command-path sequencer for the SD host. Accepts a command index and argument,
// computes the CRC7 one message bit per clock, assembles the 48-bit command
// frame and drives the shared-clock 48-bit serializer. After the frame it holds
// off for GAP_CYCLES idle clocks before reporting completion.
//
// Parameters
//   GAP_CYCLES  idle clocks after the last frame bit before cmd_done (1..63)
// Ports
//   clk         command clock (shared with the serializer)
//   reset       asynchronous, active-high reset
//   cmd_valid   host command request, accepted only while cmd_ready
//   cmd_index   6-bit command index, captured on accept
//   cmd_arg     32-bit command argument, captured on accept
//   cmd_abort   abandon the current command (ignored while idle)
//   cmd_ready   high only while idle
//   busy        high whenever not idle
//   cmd_done    one-cycle pulse once frame and gap are complete
//   ser_reset   serializer counter clear
//   ser_enable  serializer shift enable
//   ser_data    frame for the serializer, ser_data[k] is the k-th bit sent
module sd_cmd_tx_ctrl #(
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_abort,
    output logic        cmd_ready,
    output logic        busy,
    output logic        cmd_done,
    output logic        ser_reset,
    output logic        ser_enable,
    output logic [47:0] ser_data
);

    localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        LOAD,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        abort_hit;
    logic [5:0]  cnt;
    logic [5:0]  cnt_next;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [6:0]  crc_next;
    logic [39:0] msg;
    logic [5:0]  bit_sel;
    logic        fb;
    logic [47:0] frame;
    logic [47:0] frame_rev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        abort_hit  = 1'b0;
        case (state)
            IDLE:    if (cmd_valid) state_next = CRC;
            CRC:     if (cnt == 6'd39) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (cnt == 6'd47) state_next = GAP;
            GAP:     if (cnt == GAP_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state != IDLE && cmd_abort) begin
            state_next = IDLE;
            abort_hit  = 1'b1;
        end

        // Counter is cleared on every state change, so it never wraps in-state.
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (state == CRC || state == SEND || state == GAP) begin
            cnt_next = cnt + 6'd1;
        end

        // Message goes MSB first: counter value c selects msg[39-c].
        msg      = {2'b01, idx, arg};
        bit_sel  = 6'd39 - cnt;
        fb       = crc[6] ^ msg[bit_sel];
        crc_next = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

        // Frame uses crc_next so the final message bit is folded in on the
        // same edge that loads ser_data.
        frame = {2'b01, idx, arg, crc_next, 1'b1};
        for (int unsigned k = 0; k < 48; k++) begin
            frame_rev[k] = frame[47 - k];
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            arg        <= '0;
            crc        <= '0;
            ser_data   <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            cmd_done   <= 1'b0;
            ser_reset  <= 1'b1;
            ser_enable <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (state == IDLE && cmd_valid) begin
                idx <= cmd_index;
                arg <= cmd_arg;
                crc <= '0;
            end else if (state == CRC) begin
                crc <= crc_next;
            end
            if (state == CRC && state_next == LOAD) begin
                ser_data <= frame_rev;
            end
            cmd_ready  <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            cmd_done   <= (state_next == DONE);
            ser_enable <= (state_next == SEND);
            ser_reset  <= (state_next == LOAD) || abort_hit;
        end
    end

endmodule
